// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM program loader.
// Build option: ROM_LOADER_CHKSUM_EN adds the trailing checksum byte state.
package rom_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);
  localparam int DW             = 32;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
`ifdef ROM_LOADER_CHKSUM_EN
    CHK,
`endif
    DONE
  } state_t;

endpackage

// File: rtl/rom_loader_if.sv
// Stream, ROM write port and status bundle for rom_loader.
// Build option: ROM_LOADER_CHKSUM_EN (only changes loader behaviour, not this bundle).
interface rom_loader_if #(
  parameter int AW = 12
);
  import rom_loader_pkg::*;

  logic          start_i;
  logic [31:0]   base_addr_i;
  logic [AW:0]   length_i;
  logic          byte_valid_i;
  logic [7:0]    byte_data_i;
  logic          byte_ready_o;
  logic          rom_w_en_o;
  logic [31:0]   rom_w_addr_o;
  logic [DW-1:0] rom_w_data_o;
  logic          cpu_hold_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  state_t        state;

  // A byte moves on every rising edge where byte_valid_i && byte_ready_o.
  // byte_ready_o never depends on byte_valid_i; the source keeps byte_data_i
  // stable while byte_valid_i is high and the byte has not been taken.
  modport master (
    output start_i, base_addr_i, length_i, byte_valid_i, byte_data_i,
    input  byte_ready_o, rom_w_en_o, rom_w_addr_o, rom_w_data_o,
    input  cpu_hold_o, busy_o, done_o, err_o, state
  );

  modport slave (
    input  start_i, base_addr_i, length_i, byte_valid_i, byte_data_i,
    output byte_ready_o, rom_w_en_o, rom_w_addr_o, rom_w_data_o,
    output cpu_hold_o, busy_o, done_o, err_o, state
  );

endinterface

// File: rtl/rom_byte_packer.sv
// Packs accepted stream bytes little-endian into a 32-bit word.
// Build option: ROM_LOADER_CHKSUM_EN has no effect here.
module rom_byte_packer
  import rom_loader_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          xfer,
  input  logic [7:0]    byte_data,
  output logic [DW-1:0] word_o,
  output logic          word_vld_o
);

  logic [LANE_W-1:0] byte_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      byte_cnt <= '0;
      word_o   <= '0;
    end else if (xfer) begin
      word_o[{byte_cnt, 3'b000} +: 8] <= byte_data;
      byte_cnt                        <= byte_cnt + 1'b1;
    end
  end

  // High on the transfer that fills the last lane; the counter wraps to 0 here.
  assign word_vld_o = xfer && (byte_cnt == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/rom_loader.sv
// Loader FSM: collects words, writes them to the instruction ROM, holds the CPU.
// Build option: ROM_LOADER_CHKSUM_EN enables the trailing XOR checksum byte.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic         clk,
  input  logic         rst,
  rom_loader_if.slave  bus
);

  localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

  state_t        state_q, state_d;
  logic [31:0]   base_q;
  logic [AW:0]   len_q, len_in, word_cnt_q;
  logic          start_acc, wen, ready, pack_xfer, word_vld;
  logic [DW-1:0] word;
  state_t        last_state;

`ifdef ROM_LOADER_CHKSUM_EN
  assign last_state = CHK;
`else
  assign last_state = DONE;
`endif

  assign len_in    = (bus.length_i > MAX_LEN) ? MAX_LEN : bus.length_i;
  assign pack_xfer = (state_q == COLLECT) && bus.byte_valid_i;

  rom_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_acc),
    .xfer       (pack_xfer),
    .byte_data  (bus.byte_data_i),
    .word_o     (word),
    .word_vld_o (word_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    ready     = 1'b0;
    wen       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          start_acc = 1'b1;
          state_d   = (bus.length_i == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        ready = 1'b1;
        if (word_vld) state_d = WRITE;
      end
      WRITE: begin
        wen     = 1'b1;
        state_d = ((word_cnt_q + 1'b1) == len_q) ? last_state : COLLECT;
      end
`ifdef ROM_LOADER_CHKSUM_EN
      CHK: begin
        ready = 1'b1;
        if (bus.byte_valid_i) state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q     <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
    end else if (start_acc) begin
      base_q     <= bus.base_addr_i & ~32'h3;
      len_q      <= len_in;
      word_cnt_q <= '0;
    end else if (wen) begin
      word_cnt_q <= word_cnt_q + 1'b1;
    end
  end

`ifdef ROM_LOADER_CHKSUM_EN
  logic [7:0] xor_q;
  logic       err_q;

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      xor_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (pack_xfer) xor_q <= xor_q ^ bus.byte_data_i;
      if ((state_q == CHK) && bus.byte_valid_i && (bus.byte_data_i != xor_q)) err_q <= 1'b1;
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

  // Word addresses wrap modulo 2^32; the ROM itself only decodes [AW+1:2].
  assign bus.rom_w_en_o   = wen;
  assign bus.rom_w_addr_o = wen ? (base_q + 32'({word_cnt_q, 2'b00})) : 32'h0;
  assign bus.rom_w_data_o = wen ? word : '0;
  assign bus.byte_ready_o = ready;
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.cpu_hold_o   = (state_q != IDLE);
  assign bus.done_o       = (state_q == DONE);
  assign bus.state        = state_q;

endmodule
